// File: rtl/mil1553_resp_timer_ctrl.sv
// MIL-STD-1553 response-gap supervisor: arms an external down_counter after each transmitted
// word, measures the gap to the receiver's sync detect and flags ok / early / timeout.
// Optional statistics (o_max_gap_us, o_timeout_cnt) are built when MIL1553_RESP_STATS_EN is defined.
module mil1553_resp_timer_ctrl #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TICK_HZ     = 1_000_000,
  parameter int unsigned MIN_GAP_US  = 4,
  parameter int unsigned GAP_W       = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_end,
  input  logic             i_sync_det,
  input  logic             i_abort,
  output logic             o_tmr_clear,
  output logic             o_tmr_en,
  input  logic             i_tmr_done,
  output logic             o_busy,
  output logic             o_resp_ok,
  output logic             o_early,
  output logic             o_timeout,
  output logic [GAP_W-1:0] o_gap_us,
  output logic [GAP_W-1:0] o_max_gap_us,
  output logic [7:0]       o_timeout_cnt
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_SAT  = '1;
  localparam logic [GAP_W-1:0] MIN_GAP  = GAP_W'(MIN_GAP_US);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT} state_t;

  state_t           state_q;
  logic [PRE_W-1:0] presc_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_us_q;
  logic             tmr_clear_q, tmr_en_q, busy_q;
  logic             resp_ok_q, early_q, timeout_q;

  logic             tick_d;
  logic [GAP_W-1:0] gap_inc_d;

  assign tick_d    = (presc_q == PRE_LAST);
  assign gap_inc_d = (gap_q == GAP_SAT) ? gap_q : gap_q + GAP_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      gap_q       <= '0;
      gap_us_q    <= '0;
      tmr_clear_q <= 1'b0;
      tmr_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      resp_ok_q   <= 1'b0;
      early_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      tmr_clear_q <= 1'b0;
      tmr_en_q    <= 1'b0;
      resp_ok_q   <= 1'b0;
      early_q     <= 1'b0;
      timeout_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_cmd_end) begin
            state_q     <= S_ARM;
            tmr_clear_q <= 1'b1;
            busy_q      <= 1'b1;
            presc_q     <= '0;
            gap_q       <= '0;
          end
        end
        // The ARM cycle is the first prescaler cycle, so tick n lands n*DIV clocks after i_cmd_end.
        S_ARM: begin
          state_q <= S_WAIT;
          presc_q <= PRE_W'(1);
        end
        S_WAIT: begin
          if (i_abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (i_cmd_end) begin
            state_q     <= S_ARM;
            tmr_clear_q <= 1'b1;
            presc_q     <= '0;
            gap_q       <= '0;
          end else if (i_sync_det) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            gap_us_q <= gap_q;
            if (gap_q < MIN_GAP) early_q   <= 1'b1;
            else                 resp_ok_q <= 1'b1;
          end else if (i_tmr_done) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else if (tick_d) begin
            presc_q  <= '0;
            gap_q    <= gap_inc_d;
            tmr_en_q <= 1'b1;
          end else begin
            presc_q <= presc_q + PRE_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tmr_clear = tmr_clear_q;
  assign o_tmr_en    = tmr_en_q;
  assign o_busy      = busy_q;
  assign o_resp_ok   = resp_ok_q;
  assign o_early     = early_q;
  assign o_timeout   = timeout_q;
  assign o_gap_us    = gap_us_q;

`ifdef MIL1553_RESP_STATS_EN
  logic [GAP_W-1:0] max_gap_q;
  logic [7:0]       to_cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      max_gap_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      if (gap_us_q > max_gap_q) max_gap_q <= gap_us_q;
      if (timeout_q && (to_cnt_q != 8'hFF)) to_cnt_q <= to_cnt_q + 8'd1;
    end
  end

  assign o_max_gap_us  = max_gap_q;
  assign o_timeout_cnt = to_cnt_q;
`else
  assign o_max_gap_us  = '0;
  assign o_timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_mil1553_resp_timer_ctrl.sv
// Scoreboard bench for mil1553_resp_timer_ctrl with a behavioural down_counter (CYCLE_COUNT=14).
module tb_mil1553_resp_timer_ctrl;

  localparam int GAP_W = 6;
  localparam int CYCLE_COUNT = 14;
  localparam int K_OK = 0, K_EARLY = 1, K_TO = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_end = 1'b0, sync_det = 1'b0, abort_p = 1'b0;
  logic             tmr_clear, tmr_en, tmr_done;
  logic             busy, resp_ok, early, timeout;
  logic [GAP_W-1:0] gap_us, max_gap_us;
  logic [7:0]       timeout_cnt;

  typedef struct {
    int kind;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   arm_cyc = 0;
  int   dc_cnt = 0;

  always #10 clk = ~clk;

  mil1553_resp_timer_ctrl #(
    .CLK_FREQ_HZ(50_000_000), .TICK_HZ(1_000_000), .MIN_GAP_US(4), .GAP_W(GAP_W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_end(cmd_end), .i_sync_det(sync_det), .i_abort(abort_p),
    .o_tmr_clear(tmr_clear), .o_tmr_en(tmr_en), .i_tmr_done(tmr_done),
    .o_busy(busy), .o_resp_ok(resp_ok), .o_early(early), .o_timeout(timeout),
    .o_gap_us(gap_us), .o_max_gap_us(max_gap_us), .o_timeout_cnt(timeout_cnt)
  );

  // Behavioural down_counter: reload on clear, decrement per enable, done at zero.
  always @(posedge clk or posedge rst) begin
    if (rst)                       dc_cnt <= 0;
    else if (tmr_clear)            dc_cnt <= CYCLE_COUNT;
    else if (tmr_en && dc_cnt != 0) dc_cnt <= dc_cnt - 1;
  end
  assign tmr_done = (dc_cnt == 0);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: every result pulse is matched against the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst && (resp_ok || early || timeout)) begin
      int   kind;
      exp_t e;
      kind = resp_ok ? K_OK : (early ? K_EARLY : K_TO);
      chk("onehot", int'(resp_ok) + int'(early) + int'(timeout), 1);
      chk("busy_at_pulse", int'(busy), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse_kind", kind, -1);
      end else begin
        e = exp_q.pop_front();
        chk("result_kind", kind, e.kind);
        chk("gap_us", int'(gap_us), e.gap);
        if (e.kind == K_TO) chk_range("timeout_latency", cyc - arm_cyc, 700, 703);
        $display("vector: kind=%0d gap=%0d at cycle %0d", kind, gap_us, cyc);
      end
`ifndef MIL1553_RESP_STATS_EN
      chk("max_gap_tied", int'(max_gap_us), 0);
      chk("to_cnt_tied", int'(timeout_cnt), 0);
`endif
    end
  end

  // All pulse tasks are entered at a negedge; the DUT samples on the following posedge.
  task automatic pulse_cmd();
    cmd_end = 1'b1;
    @(negedge clk);
    cmd_end = 1'b0;
    arm_cyc = cyc;
  endtask

  task automatic pulse_sync();
    sync_det = 1'b1;
    @(negedge clk);
    sync_det = 1'b0;
  endtask

  task automatic pulse_abort();
    abort_p = 1'b1;
    @(negedge clk);
    abort_p = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({name, "_idle_timeout"}, int'(busy), 0);
    repeat (3) @(negedge clk);
    chk({name, "_sb_drained"}, exp_q.size(), 0);
  endtask

  typedef struct {
    int n;
    int kind;
    int gap;
  } vec_t;

  vec_t vecs[4] = '{
    '{400, K_OK, 8}, '{100, K_EARLY, 2}, '{199, K_EARLY, 3}, '{200, K_OK, 4}
  };

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_clear", int'(tmr_clear), 0);
    chk("rst_en", int'(tmr_en), 0);
    chk("rst_resp_ok", int'(resp_ok), 0);
    chk("rst_early", int'(early), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_gap", int'(gap_us), 0);
    chk("rst_max_gap", int'(max_gap_us), 0);
    chk("rst_to_cnt", int'(timeout_cnt), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Sync-det responses, including the MIN_GAP boundary (3 early, 4 ok).
    foreach (vecs[i]) begin
      exp_q.push_back('{kind: vecs[i].kind, gap: vecs[i].gap});
      pulse_cmd();
      chk("arm_clear", int'(tmr_clear), 1);
      chk("arm_busy", int'(busy), 1);
      repeat (vecs[i].n) @(negedge clk);
      pulse_sync();
      wait_idle("sync_vec");
    end

    // Timeout: o_gap_us must hold the previous value.
    exp_q.push_back('{kind: K_TO, gap: 4});
    pulse_cmd();
    wait_idle("timeout");

    // Sync coincident with down_counter done: response wins.
    exp_q.push_back('{kind: K_OK, gap: 14});
    pulse_cmd();
    repeat (2) @(negedge clk);
    begin
      int n;
      n = 0;
      while (!tmr_done && n < 1000) begin
        @(negedge clk);
        n++;
      end
      chk("same_cycle_done_seen", int'(tmr_done), 1);
    end
    pulse_sync();
    wait_idle("same_cycle");

    // Restart: second cmd_end 300 clk into WAIT re-clears the counter.
    exp_q.push_back('{kind: K_OK, gap: 4});
    pulse_cmd();
    repeat (300) @(negedge clk);
    pulse_cmd();
    chk("restart_clear", int'(tmr_clear), 1);
    chk("restart_busy", int'(busy), 1);
    repeat (200) @(negedge clk);
    pulse_sync();
    wait_idle("restart");

    // Abort: no result, later sync ignored, gap held.
    pulse_cmd();
    repeat (200) @(negedge clk);
    pulse_abort();
    chk("abort_busy", int'(busy), 0);
    repeat (50) @(negedge clk);
    pulse_sync();
    repeat (800) @(negedge clk);
    chk("abort_gap_held", int'(gap_us), 4);
    chk("abort_sb_empty", exp_q.size(), 0);

    // Asynchronous reset mid-WAIT.
    pulse_cmd();
    repeat (300) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_gap", int'(gap_us), 0);
    chk("midrst_en", int'(tmr_en), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    pulse_sync();
    repeat (5) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_gap", int'(gap_us), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
